// File: rtl/mpsoc_uart_wb_pkg.sv
// Shared types and constants for the Wishbone UART receive path.
// Holds the receiver FSM encoding, RX entry field offsets and default generics.
package mpsoc_uart_wb_pkg;

  localparam int unsigned UART_RX_OVS_DEF        = 16;
  localparam int unsigned UART_RX_MAX_BITS_DEF   = 9;
  localparam int unsigned UART_RX_FIFO_DEPTH_DEF = 16;

  localparam int unsigned UART_RX_FE   = 0;
  localparam int unsigned UART_RX_PE   = 1;
  localparam int unsigned UART_RX_BI   = 2;
  localparam int unsigned UART_RX_DATA = 3;

  typedef enum logic [2:0] {
    SR_IDLE    = 3'd0,
    SR_START   = 3'd1,
    SR_DATA    = 3'd2,
    SR_PARITY  = 3'd3,
    SR_STOP    = 3'd4,
    SR_BRKWAIT = 3'd5
  } uart_rx_state_e;

  // Word lengths outside 5..max_bits fall back to 8 bits.
  function automatic logic [3:0] uart_rx_word_len(input logic [3:0] db, input int unsigned max_bits);
    return (db >= 4'd5 && 32'(db) <= max_bits) ? db : 4'd8;
  endfunction

endpackage

// File: rtl/mpsoc_wb_uart_rx_fifo.sv
// Synchronous RX FIFO for the UART receiver.
// Tracks occupancy, sticky overrun and the number of stored entries carrying BI/PE/FE.
module mpsoc_wb_uart_rx_fifo import mpsoc_uart_wb_pkg::*; #(
  parameter int unsigned WIDTH = UART_RX_MAX_BITS_DEF + 3,
  parameter int unsigned DEPTH = UART_RX_FIFO_DEPTH_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic                     clr_overrun_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overrun_o,
  output logic                     error_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [CNTW-1:0]  cnt_q, err_cnt_q;
  logic             ovr_q;
  logic             full, empty, do_push, do_pop, in_err, head_err;

  always_comb begin
    full     = (cnt_q == CNTW'(DEPTH));
    empty    = (cnt_q == '0);
    do_pop   = pop_i && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    do_push  = push_i && (!full || do_pop);
    in_err   = |data_i[UART_RX_BI:UART_RX_FE];
    head_err = |mem_q[rp_q][UART_RX_BI:UART_RX_FE];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNTW'(1);
        2'b01:   cnt_q <= cnt_q - CNTW'(1);
        default: cnt_q <= cnt_q;
      endcase
      err_cnt_q <= err_cnt_q + CNTW'(do_push && in_err) - CNTW'(do_pop && head_err);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovr_q <= 1'b0;
    end else if (push_i && full && !do_pop && !flush_i) begin
      ovr_q <= 1'b1;
    end else if (clr_overrun_i) begin
      ovr_q <= 1'b0;
    end
  end

  always_comb begin
    data_o    = empty ? '0 : mem_q[rp_q];
    count_o   = cnt_q;
    overrun_o = ovr_q;
    error_o   = (err_cnt_q != '0);
  end

endmodule

// File: rtl/mpsoc_wb_uart_receiver_ovs.sv
// Oversampled UART receive engine with synchroniser, break/timeout detection and RX FIFO.
// Define UART_RX_MAJORITY_EN to decide each bit by a 3-sample majority vote.
module mpsoc_wb_uart_receiver_ovs import mpsoc_uart_wb_pkg::*; #(
  parameter int unsigned OVS        = UART_RX_OVS_DEF,
  parameter int unsigned MAX_BITS   = UART_RX_MAX_BITS_DEF,
  parameter int unsigned FIFO_DEPTH = UART_RX_FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          wb_rst_i,
  input  logic                          enable,
  input  logic                          srx_pad_i,
  input  logic [3:0]                    data_bits,
  input  logic                          parity_en,
  input  logic                          parity_even,
  input  logic                          parity_stick,
  input  logic                          rf_pop,
  input  logic                          rx_reset,
  input  logic                          lsr_mask,
  output logic [MAX_BITS+2:0]           rf_data_out,
  output logic [$clog2(FIFO_DEPTH):0]   rf_count,
  output logic                          rf_overrun,
  output logic                          rf_error_bit,
  output logic                          break_det,
  output logic                          timeout,
  output logic [2:0]                    rstate
);

  localparam int unsigned BW = $clog2(OVS);
  localparam int unsigned CW = $clog2(4 * (3 + MAX_BITS) * OVS) + 1;
  localparam int unsigned EW = MAX_BITS + 3;
  localparam logic [CW-1:0] BRK_RST  = CW'(10 * OVS - 1);
  localparam logic [CW-1:0] TOUT_RST = CW'(40 * OVS - 1);
  localparam logic [EW-1:0] BI_ENTRY = EW'(1) << UART_RX_BI;

  uart_rx_state_e    state_q;
  logic [1:0]        sync_q;
  logic              rxs, bit_v, sample;
  logic [BW-1:0]     bitcnt_q;
  logic [3:0]        dcnt_q, nb_q, nb_live;
  logic [MAX_BITS-1:0] shreg_q;
  logic              pe_q, pen_q, peven_q, pstick_q, brk_done_q;
  logic              push_q;
  logic [EW-1:0]     entry_q;
  logic [CW-1:0]     char_ticks, brk_q, tout_q;

  always_ff @(posedge clk) begin
    if (wb_rst_i) sync_q <= '1;
    else          sync_q <= {sync_q[0], srx_pad_i};
  end

  always_comb rxs = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q;

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      maj_q <= '1;
    end else if (enable) begin
      if (bitcnt_q == BW'(OVS/2))     maj_q[0] <= rxs;
      if (bitcnt_q == BW'(OVS/2 - 1)) maj_q[1] <= rxs;
    end
  end

  // The vote needs the third sample, so the decision is taken on that tick.
  always_comb begin
    sample = (bitcnt_q == BW'(OVS/2 - 2));
    bit_v  = (maj_q[0] & maj_q[1]) | (maj_q[0] & rxs) | (maj_q[1] & rxs);
  end
`else
  always_comb begin
    sample = (bitcnt_q == BW'(OVS/2 - 1));
    bit_v  = rxs;
  end
`endif

  always_comb begin
    nb_live    = uart_rx_word_len(data_bits, MAX_BITS);
    char_ticks = CW'((32'(nb_live) + 32'(parity_en) + 32'd2) * OVS);
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_q    <= SR_IDLE;
      bitcnt_q   <= '0;
      dcnt_q     <= '0;
      shreg_q    <= '0;
      pe_q       <= 1'b0;
      nb_q       <= 4'd8;
      pen_q      <= 1'b0;
      peven_q    <= 1'b0;
      pstick_q   <= 1'b0;
      brk_done_q <= 1'b0;
      push_q     <= 1'b0;
      entry_q    <= '0;
    end else begin
      push_q <= 1'b0;
      if (enable) begin
        bitcnt_q <= bitcnt_q - BW'(1);
        case (state_q)
          SR_IDLE: begin
            if (!rxs && !break_det) begin
              state_q  <= SR_START;
              bitcnt_q <= BW'(OVS - 2);
              dcnt_q   <= '0;
              shreg_q  <= '0;
              pe_q     <= 1'b0;
              nb_q     <= nb_live;
              pen_q    <= parity_en;
              peven_q  <= parity_even;
              pstick_q <= parity_stick;
            end
          end
          SR_START: begin
            if (sample && bit_v) begin
              state_q <= SR_IDLE;
            end else if (bitcnt_q == '0) begin
              state_q  <= SR_DATA;
              bitcnt_q <= '1;
            end
          end
          SR_DATA: begin
            if (sample) begin
              for (int unsigned i = 0; i < MAX_BITS; i++) begin
                if (dcnt_q == 4'(i)) shreg_q[i] <= bit_v;
              end
              dcnt_q <= dcnt_q + 4'd1;
            end
            if (bitcnt_q == '0) begin
              bitcnt_q <= '1;
              if (dcnt_q == nb_q) state_q <= pen_q ? SR_PARITY : SR_STOP;
            end
          end
          SR_PARITY: begin
            if (sample) begin
              pe_q <= pstick_q ? (bit_v == peven_q)
                               : (peven_q ? ((^shreg_q) ^ bit_v) : ~((^shreg_q) ^ bit_v));
            end
            if (bitcnt_q == '0) begin
              state_q  <= SR_STOP;
              bitcnt_q <= '1;
            end
          end
          SR_STOP: begin
            if (sample) begin
              push_q     <= 1'b1;
              entry_q    <= {shreg_q, 1'b0, pe_q, ~bit_v};
              brk_done_q <= 1'b0;
              state_q    <= bit_v ? SR_IDLE : SR_BRKWAIT;
            end
          end
          SR_BRKWAIT: begin
            if (rxs) begin
              state_q <= SR_IDLE;
            end else if (break_det && !brk_done_q) begin
              push_q     <= 1'b1;
              entry_q    <= BI_ENTRY;
              brk_done_q <= 1'b1;
            end
          end
          default: state_q <= SR_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i)                   brk_q <= BRK_RST;
    else if (rxs)                   brk_q <= char_ticks - CW'(1);
    else if (enable && brk_q != '0) brk_q <= brk_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i)                               tout_q <= TOUT_RST;
    else if (push_q || rf_pop || rf_count == '0) tout_q <= (char_ticks << 2) - CW'(1);
    else if (enable && tout_q != '0)            tout_q <= tout_q - CW'(1);
  end

  mpsoc_wb_uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i         (clk),
    .rst_i         (wb_rst_i),
    .push_i        (push_q),
    .pop_i         (rf_pop),
    .flush_i       (rx_reset),
    .clr_overrun_i (lsr_mask),
    .data_i        (entry_q),
    .data_o        (rf_data_out),
    .count_o       (rf_count),
    .overrun_o     (rf_overrun),
    .error_o       (rf_error_bit)
  );

  always_comb begin
    break_det = (brk_q == '0);
    timeout   = (tout_q == '0) && (rf_count != '0);
    rstate    = state_q;
  end

endmodule

// File: tb/tb_mpsoc_wb_uart_receiver_ovs.sv
// Directed bench for the oversampled UART receiver (default build, OVS=16, 9-bit max, 16 entries).
module tb_mpsoc_wb_uart_receiver_ovs;

  localparam int unsigned OVS = 16;

  logic        clk, wb_rst_i, enable, srx;
  logic [3:0]  data_bits;
  logic        parity_en, parity_even, parity_stick;
  logic        rf_pop, rx_reset, lsr_mask;
  logic [11:0] rf_data_out;
  logic [4:0]  rf_count;
  logic        rf_overrun, rf_error_bit, break_det, timeout;
  logic [2:0]  rstate;

  int unsigned n_cmp, n_bad;

  mpsoc_wb_uart_receiver_ovs #(
    .OVS        (16),
    .MAX_BITS   (9),
    .FIFO_DEPTH (16)
  ) dut (
    .clk          (clk),
    .wb_rst_i     (wb_rst_i),
    .enable       (enable),
    .srx_pad_i    (srx),
    .data_bits    (data_bits),
    .parity_en    (parity_en),
    .parity_even  (parity_even),
    .parity_stick (parity_stick),
    .rf_pop       (rf_pop),
    .rx_reset     (rx_reset),
    .lsr_mask     (lsr_mask),
    .rf_data_out  (rf_data_out),
    .rf_count     (rf_count),
    .rf_overrun   (rf_overrun),
    .rf_error_bit (rf_error_bit),
    .break_det    (break_det),
    .timeout      (timeout),
    .rstate       (rstate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One oversample tick every second clock.
  initial begin
    enable = 1'b0;
    forever begin
      @(negedge clk);
      enable = ~enable;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    @(posedge clk);
    while (!enable) @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int unsigned n);
    repeat (n) wait_tick();
  endtask

  task automatic send_bits(input logic [8:0] d, input int unsigned nb, input logic pen, input logic pbit);
    srx = 1'b0;
    wait_ticks(OVS);
    for (int unsigned i = 0; i < nb; i++) begin
      srx = d[i];
      wait_ticks(OVS);
    end
    if (pen) begin
      srx = pbit;
      wait_ticks(OVS);
    end
  endtask

  task automatic send_frame(input logic [8:0] d, input int unsigned nb, input logic pen, input logic pbit);
    send_bits(d, nb, pen, pbit);
    srx = 1'b1;
    wait_ticks(OVS);
  endtask

  task automatic pop1();
    rf_pop = 1'b1;
    @(posedge clk);
    #1;
    rf_pop = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    n_cmp = 0; n_bad = 0;
    srx = 1'b1; wb_rst_i = 1'b1; data_bits = 4'd8;
    parity_en = 1'b0; parity_even = 1'b0; parity_stick = 1'b0;
    rf_pop = 1'b0; rx_reset = 1'b0; lsr_mask = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_count", rf_count, 0);
    check("rst_data", rf_data_out, 0);
    check("rst_ovr", rf_overrun, 0);
    check("rst_err", rf_error_bit, 0);
    check("rst_brk", break_det, 0);
    check("rst_tout", timeout, 0);
    check("rst_state", rstate, 0);
    wb_rst_i = 1'b0;
    wait_ticks(4);

    // 8N1 0xA5, then character timeout with no pop
    send_bits(9'h0A5, 8, 1'b0, 1'b0);
    srx = 1'b1;
    for (int unsigned i = 0; i < 2 * OVS && rf_count == 0; i++) wait_tick();
    check("a5_count", rf_count, 1);
    check("a5_data", rf_data_out, 12'h528);
    check("a5_err", rf_error_bit, 0);
    wait_ticks(636);
    check("tout_early", timeout, 0);
    wait_ticks(4);
    check("tout_640", timeout, 1);
    pop1();
    check("a5_pop_count", rf_count, 0);
    check("tout_clr", timeout, 0);
    pop1();
    check("pop_empty_count", rf_count, 0);
    check("pop_empty_data", rf_data_out, 0);

    // 9E1: wrong parity, then correct parity
    data_bits = 4'd9; parity_en = 1'b1; parity_even = 1'b1;
    wait_ticks(OVS);
    send_frame(9'h1F3, 9, 1'b1, 1'b0);
    check("pe_count", rf_count, 1);
    check("pe_data", rf_data_out, 12'hF9A);
    check("pe_err", rf_error_bit, 1);
    send_frame(9'h0F0, 9, 1'b1, 1'b0);
    check("pe2_count", rf_count, 2);
    check("pe2_err_held", rf_error_bit, 1);
    pop1();
    check("ok_data", rf_data_out, 12'h780);
    check("pe_err_clr", rf_error_bit, 0);
    pop1();
    check("pe_drain", rf_count, 0);

    // 8-bit stick parity (expects 0) and odd parity
    data_bits = 4'd8; parity_stick = 1'b1; parity_even = 1'b1;
    wait_ticks(OVS);
    send_frame(9'h081, 8, 1'b1, 1'b0);
    check("stick_data", rf_data_out, 12'h408);
    pop1();
    parity_stick = 1'b0; parity_even = 1'b0;
    wait_ticks(OVS);
    send_frame(9'h081, 8, 1'b1, 1'b0);
    check("odd_pe_data", rf_data_out, 12'h40A);
    pop1();

    // 5-bit words and an out-of-range length treated as 8
    parity_en = 1'b0; data_bits = 4'd5;
    wait_ticks(OVS);
    send_frame(9'h015, 5, 1'b0, 1'b0);
    check("w5_data", rf_data_out, 12'h0A8);
    pop1();
    data_bits = 4'd0;
    wait_ticks(OVS);
    send_frame(9'h03C, 8, 1'b0, 1'b0);
    check("w0_data", rf_data_out, 12'h1E0);
    pop1();
    check("w_drain", rf_count, 0);

    // Break: line low for two character times
    data_bits = 4'd8;
    wait_ticks(OVS);
    srx = 1'b0;
    wait_ticks(200);
    check("brk_det", break_det, 1);
    check("brk_state", rstate, 5);
    wait_ticks(120);
    check("brk_hold", break_det, 1);
    srx = 1'b1;
    wait_ticks(4);
    check("brk_end", break_det, 0);
    check("brk_idle", rstate, 0);
    check("brk_count", rf_count, 2);
    check("brk_fe_entry", rf_data_out, 12'h001);
    pop1();
    check("brk_bi_entry", rf_data_out, 12'h004);
    check("brk_err", rf_error_bit, 1);
    pop1();
    check("brk_drain", rf_count, 0);
    check("brk_err_clr", rf_error_bit, 0);

    // Overrun: 17 bytes into 16 entries
    wait_ticks(OVS);
    for (int unsigned i = 0; i < 17; i++) begin
      b = 8'(i * 13 + 5);
      send_frame({1'b0, b}, 8, 1'b0, 1'b0);
    end
    check("ovr_count", rf_count, 16);
    check("ovr_flag", rf_overrun, 1);
    lsr_mask = 1'b1;
    @(posedge clk);
    #1;
    lsr_mask = 1'b0;
    check("ovr_clr", rf_overrun, 0);
    for (int unsigned i = 0; i < 16; i++) begin
      b = 8'(i * 13 + 5);
      check($sformatf("ovr_rd%0d", i), rf_data_out, {1'b0, b, 3'b000});
      pop1();
    end
    check("ovr_drain", rf_count, 0);

    // Flush
    send_frame(9'h055, 8, 1'b0, 1'b0);
    send_frame(9'h0AA, 8, 1'b0, 1'b0);
    check("fl_count", rf_count, 2);
    rx_reset = 1'b1;
    @(posedge clk);
    #1;
    rx_reset = 1'b0;
    check("fl_empty", rf_count, 0);
    check("fl_data", rf_data_out, 0);

    // Short glitch in idle is a false start
    wait_ticks(OVS);
    srx = 1'b0;
    wait_ticks(3);
    srx = 1'b1;
    check("gl_start", rstate, 1);
    wait_ticks(2 * OVS);
    check("gl_idle", rstate, 0);
    check("gl_nopush", rf_count, 0);

    // Reset in the middle of DATA, then a clean frame
    send_frame(9'h011, 8, 1'b0, 1'b0);
    check("mr_pre", rf_count, 1);
    srx = 1'b0;
    wait_ticks(OVS);
    srx = 1'b1;
    wait_ticks(3 * OVS);
    check("mr_data_state", rstate, 2);
    wb_rst_i = 1'b1;
    @(posedge clk);
    #1;
    check("mr_state", rstate, 0);
    check("mr_count", rf_count, 0);
    wb_rst_i = 1'b0;
    wait_ticks(2 * OVS);
    send_frame(9'h0C3, 8, 1'b0, 1'b0);
    check("mr_rx_count", rf_count, 1);
    check("mr_rx_data", rf_data_out, 12'h618);
    pop1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
